// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-slice types, stage-boundary widths and bubble constants
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    // Fetch/Decode, Decode/Execute, Execute/Memory boundary widths
    localparam int FD_CTRL_W = 8;
    localparam int FD_DATA_W = 64;
    localparam int DE_CTRL_W = 24;
    localparam int DE_DATA_W = 128;
    localparam int EM_CTRL_W = 16;
    localparam int EM_DATA_W = 96;

    // Bubbles keep every write enable low at each boundary
    localparam logic [FD_CTRL_W-1:0] FD_BUBBLE_CTRL = '0;
    localparam logic [DE_CTRL_W-1:0] DE_BUBBLE_CTRL = '0;
    localparam logic [EM_CTRL_W-1:0] EM_BUBBLE_CTRL = '0;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_slice_if.sv
// rtl/pipe_stage_slice_if.sv - upstream/downstream handshake bundle of a pipeline slice
interface pipe_stage_slice_if #(
    parameter int CTRL_W = 24,
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    // slave: the slice itself; master: the surrounding stages
    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one valid/ctrl/data entry with clear, load and hold
module pipe_entry_reg #(
    parameter int                 CTRL_W   = 24,
    parameter int                 DATA_W   = 128,
    parameter logic [CTRL_W-1:0] CLR_CTRL = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clock) begin
        if (!reset_n || clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= CLR_CTRL;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_slice.sv
// rtl/pipe_stage_slice.sv - handshaked pipeline stage with 2-entry skid, stall and flush
// Optional perf counters (stall_cycles, flush_count) under PIPE_SLICE_PERF_CNT_EN.
module pipe_stage_slice
    import pipe_pkg::*;
#(
    parameter int                 CTRL_W      = 24,
    parameter int                 DATA_W      = 128,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    pipe_stage_slice_if.slave  bus
`ifdef PIPE_SLICE_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_count
`endif
);

    pipe_state_e state_q, state_d;
    logic        in_ready_q, in_ready_d;

    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;

    logic              main_load, main_clr, main_from_skid;
    logic              skid_load, skid_clr;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;

    logic accept, pop;

    assign accept = bus.in_valid & in_ready_q & ~flush;
    assign pop    = main_valid & bus.out_ready & ~stall;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;

        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !pop) begin
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end else if (pop && !accept) begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
                    end else if (accept && pop) begin
                        main_load = 1'b1;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the skid-to-main move happens
                    if (pop) begin
                        state_d        = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign in_ready_d  = (state_d != ST_TWO);
    assign main_ctrl_d = main_from_skid ? skid_ctrl : bus.in_ctrl;
    assign main_data_d = main_from_skid ? skid_data : bus.in_data;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_entry_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_CTRL (BUBBLE_CTRL)
    ) u_main (
        .clock   (clock),
        .reset_n (reset_n),
        .clear_i (main_clr),
        .load_i  (main_load),
        .ctrl_i  (main_ctrl_d),
        .data_i  (main_data_d),
        .valid_o (main_valid),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    pipe_entry_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_CTRL (BUBBLE_CTRL)
    ) u_skid (
        .clock   (clock),
        .reset_n (reset_n),
        .clear_i (skid_clr),
        .load_i  (skid_load),
        .ctrl_i  (bus.in_ctrl),
        .data_i  (bus.in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid;
    assign bus.out_ctrl  = main_valid ? main_ctrl : BUBBLE_CTRL;
    assign bus.out_data  = main_data;

`ifdef PIPE_SLICE_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_count_q;
    logic        flush_counts;

    assign flush_counts = flush & (main_valid | skid_valid | bus.in_valid);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall && main_valid) begin
                stall_cycles_q <= sat_inc32(stall_cycles_q);
            end
            if (flush_counts) begin
                flush_count_q <= sat_inc32(flush_count_q);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid;
`endif

endmodule

// File: tb/tb_pipe_stage_slice.sv
// tb/tb_pipe_stage_slice.sv - directed self-checking bench for pipe_stage_slice
module tb_pipe_stage_slice;

    localparam int CTRL_W = 24;
    localparam int DATA_W = 128;

    logic clock = 1'b0;
    logic reset_n;
    logic stall;
    logic flush;
    int   n_checks = 0;
    int   n_errors = 0;

    pipe_stage_slice_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();

`ifdef PIPE_SLICE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    pipe_stage_slice #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .BUBBLE_CTRL ('0)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .stall        (stall),
        .flush        (flush),
        .bus          (bus)
`ifdef PIPE_SLICE_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] mk_data(input logic [CTRL_W-1:0] c);
        return {4{8'hA5, c}};
    endfunction

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic v, input logic [CTRL_W-1:0] c);
        bus.in_valid = v;
        bus.in_ctrl  = c;
        bus.in_data  = mk_data(c);
    endtask

    task automatic expect_head(input string tag, input logic [CTRL_W-1:0] c);
        check({tag, "_valid"}, DATA_W'(bus.out_valid), DATA_W'(1));
        check({tag, "_ctrl"},  DATA_W'(bus.out_ctrl),  DATA_W'(c));
        check({tag, "_data"},  bus.out_data,           mk_data(c));
    endtask

    task automatic expect_empty(input string tag);
        check({tag, "_valid"}, DATA_W'(bus.out_valid), DATA_W'(0));
        check({tag, "_bubble"}, DATA_W'(bus.out_ctrl), DATA_W'(0));
    endtask

    initial begin
        reset_n       = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        offer(1'b0, '0);
        step();
        step();
        expect_empty("rst");
        check("rst_data",  bus.out_data, '0);
        check("rst_ready", DATA_W'(bus.in_ready), DATA_W'(0));

        reset_n = 1'b1;
        step();
        check("rel_ready", DATA_W'(bus.in_ready), DATA_W'(1));

        // streaming at full rate
        bus.out_ready = 1'b1;
        offer(1'b1, 24'h000011); step(); expect_head("s11", 24'h11);
        check("s11_rdy", DATA_W'(bus.in_ready), DATA_W'(1));
        offer(1'b1, 24'h000022); step(); expect_head("s22", 24'h22);
        check("s22_rdy", DATA_W'(bus.in_ready), DATA_W'(1));
        offer(1'b1, 24'h000033); step(); expect_head("s33", 24'h33);
        check("s33_rdy", DATA_W'(bus.in_ready), DATA_W'(1));
        offer(1'b0, '0);         step(); expect_empty("s_end");

        // backpressure fills the skid; 0x99 is offered while in_ready is low
        bus.out_ready = 1'b0;
        offer(1'b1, 24'h000011); step(); expect_head("bp11", 24'h11);
        check("bp_one_rdy", DATA_W'(bus.in_ready), DATA_W'(1));
        offer(1'b1, 24'h000022); step(); expect_head("bp_two", 24'h11);
        check("bp_two_rdy", DATA_W'(bus.in_ready), DATA_W'(0));
        offer(1'b1, 24'h000099);
        bus.out_ready = 1'b1;    step(); expect_head("bp22", 24'h22);
        check("bp_back_rdy", DATA_W'(bus.in_ready), DATA_W'(1));
        offer(1'b0, '0);         step(); expect_empty("bp_end");

        // stall holds the head despite out_ready
        bus.out_ready = 1'b0;
        offer(1'b1, 24'h000044); step(); expect_head("st44", 24'h44);
        offer(1'b0, '0);
        stall = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_head($sformatf("st_hold%0d", i), 24'h44);
        end
        stall = 1'b0;            step(); expect_empty("st_pop");

        // stall while ONE still accepts into the skid
        bus.out_ready = 1'b0;
        offer(1'b1, 24'h0000A1); step();
        stall = 1'b1; bus.out_ready = 1'b1;
        offer(1'b1, 24'h0000A2); step(); expect_head("sk_a1", 24'hA1);
        check("sk_rdy", DATA_W'(bus.in_ready), DATA_W'(0));
        stall = 1'b0; offer(1'b0, '0);
        step(); expect_head("sk_a2", 24'hA2);
        step(); expect_empty("sk_end");

        // flush in TWO drops both entries and the offered 0x55
        bus.out_ready = 1'b0;
        offer(1'b1, 24'h000066); step();
        offer(1'b1, 24'h000077); step();
        check("fl_two_rdy", DATA_W'(bus.in_ready), DATA_W'(0));
        offer(1'b1, 24'h000055);
        flush = 1'b1;            step(); expect_empty("fl");
        check("fl_rdy", DATA_W'(bus.in_ready), DATA_W'(1));
        flush = 1'b0; offer(1'b0, '0);
        bus.out_ready = 1'b1;    step(); expect_empty("fl_after");

        // reset while in TWO
        bus.out_ready = 1'b0;
        offer(1'b1, 24'h000012); step();
        offer(1'b1, 24'h000034); step();
        check("mr_two_rdy", DATA_W'(bus.in_ready), DATA_W'(0));
        offer(1'b0, '0);
        reset_n = 1'b0;          step(); expect_empty("mr");
        check("mr_data", bus.out_data, '0);
        check("mr_rdy", DATA_W'(bus.in_ready), DATA_W'(0));
        reset_n = 1'b1;          step(); expect_empty("mr_rel");
        check("mr_rel_rdy", DATA_W'(bus.in_ready), DATA_W'(1));
        offer(1'b1, 24'h00005A); step(); expect_head("mr_new", 24'h5A);
        offer(1'b0, '0); bus.out_ready = 1'b1; step(); expect_empty("mr_end");

`ifdef PIPE_SLICE_PERF_CNT_EN
        reset_n = 1'b0; step();
        reset_n = 1'b1; step();
        check("pc_rst_stall", DATA_W'(stall_cycles), DATA_W'(0));
        bus.out_ready = 1'b0;
        offer(1'b1, 24'h000044); step();
        offer(1'b0, '0);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        stall = 1'b0;
        flush = 1'b1;            step();
        offer(1'b1, 24'h000045); step();
        flush = 1'b0; offer(1'b0, '0);
        step();
        check("pc_stall", DATA_W'(stall_cycles), DATA_W'(5));
        check("pc_flush", DATA_W'(flush_count),  DATA_W'(2));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_slice.md
Name: pipe_stage_slice

Overview:
- Parametrised, handshaked pipeline-stage register for the RISC-V pipeline; replaces the hand-wired per-field stage moderators between Fetch/Decode/Execute/Memory.
- Carries one control bundle (CTRL_W) and one data bundle (DATA_W) per instruction with valid/ready flow control.
- Includes a 2-entry skid buffer, so in_ready is registered.
- Stall (hazard hold) and flush (branch dump) are first-class; flush inserts a bubble with a parametrised control value.

Parameters:
- CTRL_W, 24: width of control bundle (ALU op, PC select, op-B select, mem_wEn, reg_wEn, wb reg, ...).
- DATA_W, 128: width of data bundle (PC, read data 1/2, immediate).
- BUBBLE_CTRL, 0: control value presented when no valid entry; must have all write enables at 0.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  slice can accept; registered.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- stall  in  1  hazard hold; downstream treated as not ready.
- flush  in  1  discard all held entries and the entry offered this cycle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_ctrl  out  CTRL_W  head control; BUBBLE_CTRL when out_valid=0.
- out_data  out  DATA_W  head data; don't-care when out_valid=0.

Behaviour:
- Definitions: accept = in_valid & in_ready & !flush; pop = out_valid & out_ready & !stall.
- Storage: main entry (head) and skid entry, each holding valid/ctrl/data.
- States:
  - EMPTY: no entries.
  - ONE: main valid.
  - TWO: main and skid valid.
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept & !pop -> TWO (skid loads); pop & !accept -> EMPTY; accept & pop -> ONE (main reloads).
  - TWO: pop -> ONE (skid moves to main); no accept is possible in TWO.
- in_ready: registered; 1 next cycle iff next state != TWO.
- Latency: an entry accepted at edge N is visible at out_* after edge N (1 cycle) when the slice was EMPTY or popped simultaneously.
- stall: freezes head and skid contents; accepts are still taken while not in TWO, filling the skid.
- flush:
  - Next state EMPTY; in_ready=1 next cycle.
  - The offered input is dropped; a pop in the same cycle is still counted as delivered.
  - flush has priority over stall and accept.
- Reset (reset_n=0 at edge):
  - State EMPTY; out_valid=0; out_ctrl=BUBBLE_CTRL; out_data=0.
  - in_ready=0 during reset, 1 the cycle after release.
  - Reset mid-operation discards all entries.
- out_ctrl is forced to BUBBLE_CTRL whenever main is not valid, so downstream write enables are never spuriously high.
- Data is never reordered; no combinational path from out_ready/stall to in_ready.

Optional Feature:
- Macro: PIPE_SLICE_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and flush_count[31:0]; both saturating and cleared by reset.
  - stall_cycles increments each cycle with stall & out_valid.
  - flush_count increments each cycle flush=1 with at least one valid entry or an offered in_valid.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - State enum {ST_EMPTY, ST_ONE, ST_TWO}.
  - Default widths for each stage boundary (FD_CTRL_W, DE_CTRL_W, DE_DATA_W, ...).
  - Per-boundary BUBBLE_CTRL constants.
- One sub-module, pipe_entry_reg: valid/ctrl/data register with load, clear and hold; instantiated twice (main, skid).

Test Plan:
- Reset then stream: in_valid=1 with ctrl=0x000011, 0x000022, 0x000033; out_ready=1 -> out_ctrl shows 0x11, 0x22, 0x33 on consecutive cycles one cycle after each accept; in_ready stays 1.
- Backpressure: hold out_ready=0 after 0x11 accepted, offer 0x22 -> state TWO, in_ready=0; release out_ready -> 0x11 then 0x22 delivered in order, no loss or duplicate.
- Stall: out_valid=1 with 0x44, stall=1 for 3 cycles with out_ready=1 -> out_ctrl held at 0x44, no pop; pop on first cycle stall=0.
- Flush in TWO with in_valid=1 (0x55 offered) -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, in_ready=1; 0x55 never appears.
- Reset mid-stream: reset_n=0 for 1 cycle while in TWO -> out_valid=0, out_ctrl=BUBBLE_CTRL, in_ready=0 that cycle, 1 after.
- With PIPE_SLICE_PERF_CNT_EN: 5 stalled valid cycles and 2 flushes -> stall_cycles=5, flush_count=2; preload near saturation -> counter holds at 0xFFFFFFFF.
